// File: rtl/opb_register_ppc2simulink_if.sv
// OPB slave-side bus bundle for opb_register_ppc2simulink.
// Bit numbering follows OPB: index 0 is the MSB of every bus.
//   master modport: drives OPB_* request signals, observes Sl_* responses.
//   slave  modport: observes OPB_* request signals, drives Sl_* responses.
interface opb_register_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave holding a 32-bit control word written by the PPC for fabric user logic.
// Ports:
//   OPB_Clk         single clock for bus and user logic
//   OPB_Rst_n       asynchronous active-low reset
//   bus             OPB slave bundle (address/data/byte enables in, ack/read data out)
//   user_data_out   current control word; [31:24] is OPB byte 0
//   user_data_valid one-cycle strobe in the ack cycle of every DATA write
// Map: offset bit 2 clear -> DATA (R/W), set -> WRCNT (RO, 16-bit write counter).
module opb_register_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst_n,
  opb_register_ppc2simulink_if.slave        bus,
  output logic [31:0]                       user_data_out,
  output logic                              user_data_valid
);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e r_state, w_state_next;

  logic [C_OPB_AWIDTH-1:0] w_addr;
  logic [C_OPB_DWIDTH-1:0] w_wdata;
  logic [3:0]              w_be;
  logic                    w_hit;
  logic                    w_sel_cnt;
  logic                    w_start;
  logic                    w_data_wr;
  logic                    w_rd;

  logic [31:0] r_data;
  logic [15:0] r_wrcnt;
  logic [31:0] r_rdata;
  logic        r_valid;

  logic unused_seqaddr;
  assign unused_seqaddr = bus.OPB_seqAddr;

  // Value copies: OPB bit 0 lands on bit 31, so BE[0] becomes w_be[3].
  assign w_addr  = bus.OPB_ABus;
  assign w_wdata = bus.OPB_DBus;
  assign w_be    = bus.OPB_BE;

  assign w_hit     = bus.OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_sel_cnt = |((w_addr - C_BASEADDR) & 32'h0000_0004);
  assign w_start   = (r_state == StIdle) && w_hit;
  assign w_data_wr = w_start && !bus.OPB_RNW && !w_sel_cnt;
  assign w_rd      = w_start && bus.OPB_RNW;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WAIT holds off a second ack while the master keeps select asserted.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_hit) w_state_next = StAck;
      StAck:   w_state_next = StWait;
      StWait:  if (!bus.OPB_select) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_data  <= C_INIT_VALUE;
      r_wrcnt <= 16'h0000;
      r_rdata <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_data_wr;
      if (w_data_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[3-i]) r_data[31-8*i -: 8] <= w_wdata[31-8*i -: 8];
        end
        // Counts even with no byte enables set; wraps naturally at 16 bits.
        r_wrcnt <= r_wrcnt + 16'd1;
      end
      if (w_rd) begin
        r_rdata <= w_sel_cnt ? {16'h0000, r_wrcnt} : r_data;
      end
    end
  end

  // Read data is gated to the ack cycle because the OPB data bus is OR-wired.
  assign bus.Sl_xferAck = (r_state == StAck);
  assign bus.Sl_DBus    = (r_state == StAck) ? r_rdata : 32'h0000_0000;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

  assign user_data_out   = r_data;
  assign user_data_valid = r_valid;

endmodule
